// File: rtl/program_sequencer.sv
// program_sequencer: fetches header/operand/IR records from byte memory and drives the accumulator controller.
// Optional macro SEQ_STEP_EN adds a step input that gates each advance out of CAP.
module program_sequencer #(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [1:0]        ctrl_enable,
    output logic [7:0]        ctrl_data,
    input  logic [7:0]        ctrl_result,
    input  logic [7:0]        ctrl_ir,
    output logic [7:0]        result,
    output logic [1:0]        result_flags,
    output logic              result_valid,
    output logic [7:0]        instr_count,
    output logic              busy,
`ifdef SEQ_STEP_EN
    output logic              done,
    input  logic              step
`else
    output logic              done
`endif
);

    typedef enum logic [3:0] {IDLE, HDR, FR0, LR0, FR1, LR1, FIR, LIR, EXEC, CAP, HALT} state_e;

    state_e            state_q, fetch_d;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        en_q, en_d;
    logic [7:0]        data_q, result_q, cnt_q, cnt_d;
    logic [1:0]        flags_q;
    logic              valid_q, busy_q, done_q, ld_r1_q, advance;
    logic              unused_ir;

    assign unused_ir = ^ctrl_ir[5:0];

`ifdef SEQ_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    always_comb begin
        addr_d  = addr_q + 1'b1;
        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        fetch_d = (state_q == FR0) ? LR0 :
                  (state_q == FR1) ? LR1 :
                  (state_q == FIR) ? LIR :
                  mem_rdata[7]     ? HALT :
                  mem_rdata[0]     ? FR0 :
                  mem_rdata[1]     ? FR1 : FIR;
        en_d    = (state_q == FR0) ? 2'b01 :
                  (state_q == FR1) ? 2'b10 :
                  (state_q == FIR) ? 2'b11 : 2'b00;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            addr_q   <= START_ADDR;
            en_q     <= 2'b00;
            data_q   <= 8'h00;
            result_q <= 8'h00;
            flags_q  <= 2'b00;
            valid_q  <= 1'b0;
            cnt_q    <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ld_r1_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE, HALT: if (start) begin
                    state_q <= HDR;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                    cnt_q   <= 8'h00;
                    addr_q  <= START_ADDR;
                end
                // Request goes up one cycle after entry; the ack edge latches data and primes the next load.
                HDR, FR0, FR1, FIR: begin
                    if (!req_q) req_q <= 1'b1;
                    else if (mem_ack) begin
                        req_q   <= 1'b0;
                        addr_q  <= addr_d;
                        state_q <= fetch_d;
                        en_q    <= en_d;
                        if (state_q == HDR) begin
                            ld_r1_q <= mem_rdata[1];
                            busy_q  <= !mem_rdata[7];
                            done_q  <= mem_rdata[7];
                        end else data_q <= mem_rdata;
                    end
                end
                LR0: begin
                    en_q    <= 2'b00;
                    state_q <= ld_r1_q ? FR1 : FIR;
                end
                LR1: begin
                    en_q    <= 2'b00;
                    state_q <= FIR;
                end
                LIR: begin
                    en_q    <= 2'b00;
                    state_q <= EXEC;
                end
                // The controller executes on the EXEC negedge, so its result is settled at this edge.
                EXEC: begin
                    cnt_q    <= cnt_d;
                    result_q <= ctrl_result;
                    flags_q  <= ctrl_ir[7:6];
                    valid_q  <= 1'b1;
                    state_q  <= CAP;
                end
                CAP: if (advance) state_q <= HDR;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req      = req_q;
    assign mem_addr     = addr_q;
    assign ctrl_enable  = en_q;
    assign ctrl_data    = data_q;
    assign result       = result_q;
    assign result_flags = flags_q;
    assign result_valid = valid_q;
    assign instr_count  = cnt_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: random and directed record programs checked against a record-walking reference model.
module tb_program_sequencer;

    localparam logic [7:0] SA = 8'hFE;

    logic       clk = 1'b0;
    logic       reset_n, start, mem_req, mem_ack, result_valid, busy, done;
    logic [7:0] mem_addr, mem_rdata, ctrl_data, ctrl_result, ctrl_ir, result, instr_count;
    logic [1:0] ctrl_enable, result_flags;

    int         checks = 0, errors = 0;
    logic [7:0] mem [256];
    logic [7:0] exp_fetch[$];
    logic [9:0] exp_load[$];
    logic [9:0] exp_res[$];
    int         cur_wait = 0, nres = 0, viol = 0, exp_cnt = 0;
    bit         rnd_wait = 0, spur = 0, chk_on = 0;
    logic [7:0] ctl_r0, ctl_r1, m_r0, m_r1, m_dout, exp_end;

    program_sequencer #(.ADDR_W(8), .START_ADDR(SA)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ctrl_enable(ctrl_enable), .ctrl_data(ctrl_data), .ctrl_result(ctrl_result), .ctrl_ir(ctrl_ir),
        .result(result), .result_flags(result_flags), .result_valid(result_valid),
        .instr_count(instr_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Controller ALU: op 0 add, 1 sub (carry = borrow), 2 and, 3 xor; returns {carry, result}.
    function automatic logic [8:0] alu(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
        return op == 2'd0 ? {1'b0, x} + {1'b0, y} :
               op == 2'd1 ? {1'b0, x} - {1'b0, y} :
               op == 2'd2 ? {1'b0, x & y} : {1'b0, x ^ y};
    endfunction

    // Memory responder: acks after cur_wait cycles of request, optionally strobes stray acks.
    initial begin
        int cnt;
        bit pend;
        logic [7:0] paddr, e;
        cnt = 0; pend = 0; paddr = 0;
        mem_ack = 0; mem_rdata = 0;
        forever begin
            @(negedge clk);
            mem_ack = 0;
            if (!reset_n) begin
                cnt = 0; pend = 0;
            end else begin
                if (pend && (!mem_req || mem_addr !== paddr)) viol++;
                if (mem_req && cnt >= cur_wait) begin
                    mem_ack = 1; mem_rdata = mem[mem_addr]; cnt = 0;
                    if (chk_on) begin
                        e = exp_fetch.size() != 0 ? exp_fetch.pop_front() : 8'hxx;
                        checks++;
                        if (mem_addr !== e) begin errors++; $display("FAIL fetch_addr got %h expected %h", mem_addr, e); end
                    end
                    if (rnd_wait) cur_wait = $urandom_range(0, 3);
                end else if (mem_req) cnt++;
                else if (spur && $urandom_range(0, 3) == 0) begin mem_ack = 1; mem_rdata = 8'($urandom); end
                pend = mem_req && !mem_ack;
                paddr = mem_addr;
            end
        end
    end

    // Controller model plus load/result observers.
    initial begin
        logic [8:0] t;
        logic [9:0] e;
        ctrl_result = 0; ctrl_ir = 0; ctl_r0 = 0; ctl_r1 = 0;
        forever begin
            @(negedge clk);
            if (result_valid) begin
                nres++;
                if (chk_on) begin
                    e = exp_res.size() != 0 ? exp_res.pop_front() : 10'hxxx;
                    checks++;
                    if ({result_flags, result} !== e) begin errors++; $display("FAIL result got %h/%h expected %h/%h", result_flags, result, e[9:8], e[7:0]); end
                end
            end
            if (ctrl_enable != 2'b00 && chk_on) begin
                e = exp_load.size() != 0 ? exp_load.pop_front() : 10'hxxx;
                checks++;
                if ({ctrl_enable, ctrl_data} !== e) begin errors++; $display("FAIL load got en=%b data=%h expected en=%b data=%h", ctrl_enable, ctrl_data, e[9:8], e[7:0]); end
            end
            if (ctrl_enable == 2'b01) ctl_r0 = ctrl_data;
            else if (ctrl_enable == 2'b10) ctl_r1 = ctrl_data;
            else if (ctrl_enable == 2'b11) ctrl_ir = ctrl_data;
            else if (ctrl_ir[1:0] != 2'b00) begin
                t = alu(ctrl_ir[3:2], ctl_r0, ctl_r1);
                ctrl_result = t[7:0];
                if (ctrl_ir[0]) ctl_r0 = t[7:0];
                if (ctrl_ir[1]) ctl_r1 = t[7:0];
                ctrl_ir = {t[7:0] == 8'h00, t[8], ctrl_ir[5:2], 2'b00};
            end
        end
    end

    task automatic sync_models();
        ctl_r0 = 0; ctl_r1 = 0; ctrl_result = 0; ctrl_ir = 0;
        m_r0 = 0; m_r1 = 0; m_dout = 0;
    endtask

    task automatic load_prog(input logic [7:0] p[$]);
        for (int i = 0; i < p.size(); i++) mem[8'(SA + i)] = p[i];
    endtask

    // Walks the program record by record to predict fetches, loads, results, count and end address.
    task automatic ref_build();
        logic [7:0] a, h, b;
        logic [8:0] t;
        int n;
        exp_fetch.delete(); exp_load.delete(); exp_res.delete();
        a = SA; n = 0;
        for (int g = 0; g < 256; g++) begin
            exp_fetch.push_back(a); h = mem[a]; a++;
            if (h[7]) break;
            if (h[0]) begin exp_fetch.push_back(a); m_r0 = mem[a]; exp_load.push_back({2'b01, m_r0}); a++; end
            if (h[1]) begin exp_fetch.push_back(a); m_r1 = mem[a]; exp_load.push_back({2'b10, m_r1}); a++; end
            exp_fetch.push_back(a); b = mem[a]; exp_load.push_back({2'b11, b}); a++; n++;
            if (b[1:0] != 2'b00) begin
                t = alu(b[3:2], m_r0, m_r1);
                m_dout = t[7:0];
                if (b[0]) m_r0 = m_dout;
                if (b[1]) m_r1 = m_dout;
                exp_res.push_back({m_dout == 8'h00, t[8], m_dout});
            end else exp_res.push_back({b[7:6], m_dout});
        end
        exp_cnt = n > 255 ? 255 : n;
        exp_end = a;
    endtask

    task automatic pulse_start();
        start = 1; @(negedge clk); start = 0;
    endtask

    task automatic run_wait(input int lim);
        pulse_start();
        for (int i = 0; i < lim && done !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 0; start = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_req, mem_addr, ctrl_enable, ctrl_data, result, result_flags, result_valid, instr_count, busy, done}
            !== {1'b0, SA, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_values got req=%b addr=%h en=%b busy=%b done=%b cnt=%h", mem_req, mem_addr, ctrl_enable, busy, done, instr_count);
        end
        start = 0; reset_n = 1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] p[$];
        p = '{8'h00, 8'h1C, 8'h80};
        load_prog(p); sync_models(); ref_build(); chk_on = 1; nres = 0;
        run_wait(200);
        checks++;
        if ({done, busy, instr_count, mem_addr} !== {1'b1, 1'b0, 8'd1, 8'(SA + 3)}) begin errors++; $display("FAIL basic_end got done=%b busy=%b cnt=%0d addr=%h", done, busy, instr_count, mem_addr); end
        checks++;
        if (nres !== 1) begin errors++; $display("FAIL basic_valid_pulses got %0d expected 1", nres); end
        checks++;
        if (exp_fetch.size() + exp_load.size() + exp_res.size() !== 0) begin errors++; $display("FAIL basic_leftover got %0d expected 0", exp_fetch.size() + exp_load.size() + exp_res.size()); end
    endtask

    task automatic test_loads();
        logic [7:0] p[$];
        p = '{8'h03, 8'h05, 8'h03, 8'h01, 8'h80};
        load_prog(p); sync_models(); ref_build(); nres = 0;
        run_wait(200);
        checks++;
        if ({result_flags, result} !== 10'h008) begin errors++; $display("FAIL loads_result got %h/%h expected 0/08", result_flags, result); end
        checks++;
        if ({done, instr_count, mem_addr} !== {1'b1, 8'd1, 8'(SA + 5)}) begin errors++; $display("FAIL loads_end got done=%b cnt=%0d addr=%h", done, instr_count, mem_addr); end
        checks++;
        if (exp_load.size() + exp_res.size() !== 0) begin errors++; $display("FAIL loads_leftover got %0d expected 0", exp_load.size() + exp_res.size()); end
    endtask

    task automatic test_wait();
        logic [7:0] p[$];
        p = '{8'h03, 8'h05, 8'h03, 8'h01, 8'h80};
        load_prog(p); sync_models(); ref_build(); viol = 0; cur_wait = 3;
        run_wait(400);
        cur_wait = 0;
        checks++;
        if ({result_flags, result} !== 10'h008) begin errors++; $display("FAIL wait_result got %h/%h expected 0/08", result_flags, result); end
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL wait_req_stable got %0d violations expected 0", viol); end
        checks++;
        if ({done, instr_count, mem_addr} !== {1'b1, 8'd1, 8'(SA + 5)}) begin errors++; $display("FAIL wait_end got done=%b cnt=%0d addr=%h", done, instr_count, mem_addr); end
    endtask

    task automatic test_wrap();
        logic [7:0] p[$];
        p = '{8'h01, 8'hAA, 8'h02, 8'h80};
        load_prog(p); sync_models(); ref_build();
        run_wait(200);
        checks++;
        if ({result_flags, result} !== 10'h0AA) begin errors++; $display("FAIL wrap_result got %h/%h expected 0/aa", result_flags, result); end
        checks++;
        if ({done, mem_addr} !== {1'b1, 8'h02}) begin errors++; $display("FAIL wrap_addr got done=%b addr=%h expected 1/02", done, mem_addr); end
        checks++;
        if (exp_fetch.size() !== 0) begin errors++; $display("FAIL wrap_fetches got %0d unfetched expected 0", exp_fetch.size()); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] p[$];
        p = '{8'h03, 8'h11, 8'h22, 8'h05, 8'h80};
        load_prog(p); sync_models(); ref_build();
        pulse_start();
        for (int i = 0; i < 100 && ctrl_enable !== 2'b10; i++) @(negedge clk);
        checks++;
        if (ctrl_enable !== 2'b10) begin errors++; $display("FAIL reach_lr1 got en=%b expected 10", ctrl_enable); end
        #2 reset_n = 0;
        #1;
        checks++;
        if ({mem_req, mem_addr, ctrl_enable, ctrl_data, result_valid, instr_count, busy, done}
            !== {1'b0, SA, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++; $display("FAIL mid_reset got req=%b addr=%h en=%b data=%h cnt=%h busy=%b", mem_req, mem_addr, ctrl_enable, ctrl_data, instr_count, busy);
        end
        @(negedge clk);
        reset_n = 1;
        sync_models(); ref_build(); nres = 0;
        run_wait(200);
        checks++;
        if ({result_flags, result} !== {2'b01, 8'hEF}) begin errors++; $display("FAIL rerun_result got %h/%h expected 1/ef", result_flags, result); end
        checks++;
        if ({done, instr_count, nres} !== {1'b1, 8'd1, 32'd1}) begin errors++; $display("FAIL rerun_count got done=%b cnt=%0d pulses=%0d expected 1/1/1", done, instr_count, nres); end
    endtask

    task automatic test_random();
        logic [7:0] h;
        int k;
        rnd_wait = 1; spur = 1;
        for (int it = 0; it < 10; it++) begin
            k = 0;
            for (int r = 0; r < $urandom_range(1, 8); r++) begin
                h = {1'b0, 7'($urandom)};
                mem[8'(SA + k)] = h; k++;
                if (h[0]) begin mem[8'(SA + k)] = 8'($urandom); k++; end
                if (h[1]) begin mem[8'(SA + k)] = 8'($urandom); k++; end
                mem[8'(SA + k)] = 8'($urandom); k++;
            end
            mem[8'(SA + k)] = {1'b1, 7'($urandom)};
            sync_models(); ref_build();
            run_wait(3000);
            checks++;
            if ({done, busy, instr_count, mem_addr} !== {1'b1, 1'b0, 8'(exp_cnt), exp_end}) begin
                errors++; $display("FAIL random_end it=%0d got done=%b busy=%b cnt=%0d addr=%h expected 1/0/%0d/%h", it, done, busy, instr_count, mem_addr, exp_cnt, exp_end);
            end
            checks++;
            if (exp_fetch.size() + exp_load.size() + exp_res.size() !== 0) begin errors++; $display("FAIL random_leftover it=%0d got %0d expected 0", it, exp_fetch.size() + exp_load.size() + exp_res.size()); end
        end
        rnd_wait = 0; spur = 0; cur_wait = 0;
    endtask

    task automatic test_saturate();
        chk_on = 0;
        for (int i = 0; i < 256; i++) mem[i] = (i % 2 == 0) ? 8'h04 : 8'hC0;
        nres = 0;
        pulse_start();
        for (int i = 0; i < 3000 && nres < 150; i++) @(negedge clk);
        pulse_start();
        checks++;
        if ({busy, done, instr_count} !== {1'b1, 1'b0, 8'(nres)} || nres != 150) begin
            errors++; $display("FAIL start_while_busy got busy=%b done=%b cnt=%0d pulses=%0d expected 1/0/150/150", busy, done, instr_count, nres);
        end
        for (int i = 0; i < 3000 && nres < 300; i++) @(negedge clk);
        checks++;
        if ({busy, instr_count} !== {1'b1, 8'hFF} || nres != 300) begin
            errors++; $display("FAIL saturate got busy=%b cnt=%0d pulses=%0d expected 1/255/300", busy, instr_count, nres);
        end
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        checks++;
        if ({busy, instr_count, mem_req} !== {1'b0, 8'h00, 1'b0}) begin errors++; $display("FAIL saturate_reset got busy=%b cnt=%0d req=%b", busy, instr_count, mem_req); end
    endtask

    initial begin
        reset_n = 0; start = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h80;
        test_reset();
        test_basic();
        test_loads();
        test_wait();
        test_wrap();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Autonomous front end for the 2-register accumulator controller (IR/R0/R1 + ALU, loads sampled on negedge clk).
- Fetches variable-length instruction records from a byte-wide program memory over a req/ack handshake.
- Drives the controller's 2-bit enable and 8-bit data bus to sequence operand loads, the IR load and one execute cycle.
- Captures each ALU result and its flags, counts executed instructions, and stops on a halt record.

Parameters:
ADDR_W, 8, program memory address width; the address wraps modulo 2^ADDR_W.
START_ADDR, 0, first fetch address after start.

Ports:
clk  in  1  system clock; the block updates on posedge, and the controller samples on negedge.
reset_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse that begins execution at START_ADDR; ignored while busy=1.
mem_req  out  1  read request; held high until mem_ack.
mem_addr  out  ADDR_W  read address; stable while mem_req=1.
mem_ack  in  1  one-cycle read-complete strobe; mem_rdata is valid in the same cycle.
mem_rdata  in  8  read data.
ctrl_enable  out  2  to controller enable: 11=IR load, 10=R1 load, 01=R0 load, 00=execute.
ctrl_data  out  8  to controller data_in.
ctrl_result  in  8  controller data_out (ALU result).
ctrl_ir  in  8  controller IR; bits [7:6] are the flags.
result  out  8  last captured ALU result.
result_flags  out  2  flags captured with result.
result_valid  out  1  one-cycle pulse when result and result_flags update.
instr_count  out  8  number of executed instructions; saturates at 255.
busy  out  1  high from accepted start until HALT.
done  out  1  high in HALT; cleared by the next start.
step  in  1  single-step advance (present only with SEQ_STEP_EN).

Behaviour:
- Record format:
  - Header byte: bit7=halt, bit1=ld_r1, bit0=ld_r0; other bits reserved, ignored.
  - The header is followed by an R0 byte (only if ld_r0), then an R1 byte (only if ld_r1), then the IR byte.
  - A halt header has no further bytes.
- Reset values: state IDLE, mem_req=0, mem_addr=START_ADDR, ctrl_enable=00, ctrl_data=0, result=0, result_flags=0, result_valid=0, instr_count=0, busy=0, done=0.
- States: IDLE, HDR, FR0, LR0, FR1, LR1, FIR, LIR, EXEC, CAP, HALT.
- IDLE:
  - On start, go to HDR; set busy=1, done=0, instr_count=0, mem_addr=START_ADDR.
- Fetch states (HDR, FR0, FR1, FIR):
  - Assert mem_req with mem_addr.
  - On mem_ack: latch mem_rdata, drop mem_req the next cycle, increment mem_addr (wraps at 2^ADDR_W-1 to 0).
  - Unbounded wait; no timeout.
- After HDR:
  - halt=1: go to HALT.
  - Else ld_r0: go to FR0.
  - Else ld_r1: go to FR1.
  - Else: go to FIR.
- Load states:
  - LR0: ctrl_enable=01, ctrl_data=fetched byte, exactly one cycle.
  - LR1: ctrl_enable=10, same rule.
  - LIR: ctrl_enable=11, same rule.
  - LR0 is followed by FR1 if ld_r1, else FIR. LR1 is followed by FIR. LIR is followed by EXEC.
  - Data and enable are set on posedge so both are stable at the controller's negedge.
- EXEC:
  - ctrl_enable=00 for one cycle; this is the counted execute.
  - instr_count increments (saturating).
- CAP:
  - Sample ctrl_result and ctrl_ir[7:6] into result/result_flags; pulse result_valid.
  - Then go to HDR at the current mem_addr.
- Non-load states: ctrl_enable=00.
  - Repeat executes are benign because the controller clears its destination field after a writeback.
  - ctrl_data holds its last value.
- Latency:
  - Minimum record with 0 wait states: each fetch takes 2 cycles (req, ack); each load and EXEC/CAP takes 1 cycle.
  - A header+IR record with an immediate ack takes 7 cycles from entering HDR to result_valid.
- HALT: busy=0, done=1; start restarts at START_ADDR.
- Boundary conditions:
  - start while busy: ignored.
  - mem_ack while mem_req=0: ignored.
  - Reset mid-operation: everything returns to reset values immediately; any in-flight request is abandoned.
  - Simultaneous start and reset_n low: reset wins.

Optional Feature:
SEQ_STEP_EN:
- Defined: the step port exists. The block waits in CAP (after result_valid) until step=1, then proceeds to HDR. A step coinciding with the result_valid cycle counts.
- Undefined: there is no step port; CAP always proceeds immediately.

Test Plan:
- Reset, then start, with memory {00, 1C, 80}, an immediate ack, and controller R0=R1=unknown, IR=1C -> one EXEC cycle; result_valid once; instr_count=1; done=1 after the halt fetch.
- Header 03, R0=05, R1=03, IR=(add, destination R0=01): ctrl_enable sequence 01,10,11,00 with ctrl_data 05,03,IR -> result=08, result_flags=ctrl_ir[7:6].
- Memory ack delayed 3 cycles on every fetch -> mem_addr is stable and mem_req is held during each wait; same results as the 0-wait run.
- START_ADDR=FE with a 3-byte record at FE, FF, 00 -> mem_addr wraps to 00; the header at 01 is fetched next.
- reset_n low during LR1, then start again -> outputs return to reset values; the rerun produces the correct result and instr_count=1 per record.
- 300 non-halt records -> instr_count saturates at 255; a start pulse while busy has no effect.
